// File: rtl/io_out_fifo_if.sv
// io_out_fifo_if: processor write side and consumer valid/ready side of the output FIFO
interface io_out_fifo_if #(
    parameter int NUBITS = 16,
    parameter int NBIOOU = 2
);
    logic [NUBITS-1:0] io_out;
    logic [NBIOOU-1:0] addr_out;
    logic              out_en;
    logic [NUBITS-1:0] dout_data;
    logic [NBIOOU-1:0] dout_addr;
    logic              dout_valid;
    logic              dout_ready;
    modport master (
        output io_out, addr_out, out_en, dout_ready,
        input  dout_data, dout_addr, dout_valid
    );
    modport slave (
        input  io_out, addr_out, out_en, dout_ready,
        output dout_data, dout_addr, dout_valid
    );
endinterface

// File: rtl/io_out_fifo.sv
// io_out_fifo: circular FWFT buffer of {addr,data} OUT writes drained over valid/ready
module io_out_fifo #(
    parameter  int NUBITS = 16,
    parameter  int NBIOOU = 2,
    parameter  int FDEPTH = 8,
    localparam int FDW    = $clog2(FDEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    io_out_fifo_if.slave   bus,
    output logic           o_full,
    output logic [FDW:0]   o_count,
    output logic           o_ovf,
    input  logic           i_ovf_clr
);
    logic [FDW:0]               r_wr_ptr;
    logic [FDW:0]               r_rd_ptr;
    logic [FDW:0]               r_count;
    logic [FDW:0]               w_count_nxt;
    logic                       r_full;
    logic                       r_valid;
    logic                       r_ovf;
    logic                       w_push;
    logic                       w_pop;
    logic [NBIOOU+NUBITS-1:0]   r_mem [FDEPTH];

    assign w_pop  = r_valid & bus.dout_ready;
    assign w_push = bus.out_en & (~r_full | w_pop);

    // Occupancy after this edge; full and valid are registered from it so they track the pointers
    always_comb
        w_count_nxt = (w_push & ~w_pop) ? r_count + (FDW+1)'(1) :
                      (w_pop & ~w_push) ? r_count - (FDW+1)'(1) : r_count;

    // Pointers, occupancy flags and sticky overflow; a dropped write beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + (FDW+1)'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + (FDW+1)'(1) : r_rd_ptr;
            r_count  <= w_count_nxt;
            r_full   <= w_count_nxt == (FDW+1)'(FDEPTH);
            r_valid  <= w_count_nxt != '0;
            r_ovf    <= (bus.out_en & ~w_push) ? 1'b1 : i_ovf_clr ? 1'b0 : r_ovf;
        end
    end

    // Storage array is never cleared; only the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[FDW-1:0]] <= {bus.addr_out, bus.io_out};
    end

    assign {bus.dout_addr, bus.dout_data} = r_mem[r_rd_ptr[FDW-1:0]];
    assign bus.dout_valid = r_valid;
    assign o_full         = r_full;
    assign o_count        = r_count;
    assign o_ovf          = r_ovf;
endmodule

// File: tb/tb_io_out_fifo.sv
// tb_io_out_fifo: directed and random steps checked against a queue model of the FIFO
module tb_io_out_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        full;
    logic [3:0]  count;
    logic        ovf;
    logic        ovf_clr;
    int          n_chk = 0;
    int          n_err = 0;
    logic [17:0] q[$];
    logic        m_ovf;

    io_out_fifo_if #(.NUBITS(16), .NBIOOU(2)) bus ();

    io_out_fifo #(.NUBITS(16), .NBIOOU(2), .FDEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .o_full    (full),
        .o_count   (count),
        .o_ovf     (ovf),
        .i_ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == 8));
        chk("valid", 32'(bus.dout_valid), 32'(q.size() != 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (q.size() != 0) chk("head", 32'({bus.dout_addr, bus.dout_data}), 32'(q[0]));
    endtask

    // One clock: apply inputs, advance the model by the FIFO rules, then compare just after the edge
    task automatic step(input logic en, input logic [1:0] a, input logic [15:0] d,
                        input logic rdy, input logic clr);
        logic        pop, push, hold;
        logic [17:0] head;
        bus.out_en     = en;
        bus.addr_out   = a;
        bus.io_out     = d;
        bus.dout_ready = rdy;
        ovf_clr        = clr;
        hold = q.size() != 0 && !rdy;
        head = hold ? q[0] : '0;
        pop  = q.size() != 0 && rdy;
        push = en && (q.size() < 8 || pop);
        if (pop) void'(q.pop_front());
        if (push) q.push_back({a, d});
        if (en && !push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        if (hold) chk("hold", 32'({bus.dout_addr, bus.dout_data}), 32'(head));
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && q.size() != 0; i++) step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_en = 1'b0; bus.addr_out = '0; bus.io_out = '0; bus.dout_ready = 1'b0;
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        // single write appears on the next cycle
        step(1'b1, 2'd2, 16'h1234, 1'b0, 1'b0);
        chk("single_data", 32'(bus.dout_data), 32'h1234);
        chk("single_addr", 32'(bus.dout_addr), 32'd2);
        drain();
        // fill, overflow with DEAD, drain in order
        for (int i = 0; i < 8; i++) step(1'b1, 2'(i), 16'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        step(1'b1, 2'd3, 16'hDEAD, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 32'(bus.dout_data), 32'(i));
            step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(bus.dout_valid), 32'd0);
        step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
        // empty with ready and write: push only
        step(1'b1, 2'd1, 16'h5555, 1'b1, 1'b0);
        chk("empty_push", 32'(count), 32'd1);
        drain();
        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++) step(1'b1, 2'(i), 16'h10 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 2'd1, 16'h00AA, 1'b1, 1'b0);
        chk("pp_count", 32'(count), 32'd8);
        chk("pp_ovf", 32'(ovf), 32'd0);
        for (int i = 1; i < 8; i++) begin
            chk("pp_order", 32'(bus.dout_data), 32'h10 + 32'(i));
            step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        end
        chk("pp_last", 32'(bus.dout_data), 32'h00AA);
        drain();
        // wrap with toggling back-pressure
        for (int i = 0; i < 20; i++)
            step(1'b1, 2'($urandom), 16'($urandom), 1'(~i & 1), 1'b0);
        for (int i = 0; i < 24 && q.size() != 0; i++) step(1'b0, 2'd0, 16'h0, 1'(i & 1), 1'b0);
        chk("wrap_empty", 32'(q.size()), 32'd0);
        // overflow beats clear, then clear alone
        for (int i = 0; i < 8; i++) step(1'b1, 2'(i), 16'(i), 1'b0, 1'b0);
        step(1'b1, 2'd0, 16'hBEEF, 1'b0, 1'b1);
        chk("clr_race", 32'(ovf), 32'd1);
        step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
        chk("clr_alone", 32'(ovf), 32'd0);
        drain();
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 60), 2'($urandom), 16'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5));
        drain();
        // asynchronous reset mid-stream with five entries
        for (int i = 0; i < 5; i++) step(1'b1, 2'(i), 16'h40 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 2'd0, 16'h0, 1'b1, 1'b0);
        chk("pre_reset", 32'(count), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
        step(1'b1, 2'd3, 16'hC0DE, 1'b0, 1'b0);
        chk("post_reset", 32'(bus.dout_data), 32'hC0DE);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
